// File: rtl/usb_serial_rx_buffer.sv
// rtl/usb_serial_rx_buffer.sv - EP01 OUT receive byte buffer with space-based ready and valid/ready output
module usb_serial_rx_buffer #(
    parameter int ASIZE    = 10,
    parameter int MIN_FREE = 32
) (
    input  logic           clk,
    input  logic           rstn,
    input  logic           clear,
    input  logic [7:0]     in_data,
    input  logic           in_valid,
    output logic           in_ready,
    output logic [7:0]     out_data,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [ASIZE:0] level,
    output logic           overflow
);

    localparam int             DEPTH      = 1 << ASIZE;
    localparam logic [ASIZE:0] FULL_LEVEL = (ASIZE + 1)'(DEPTH);
    localparam logic [ASIZE:0] MIN_FREE_L = (ASIZE + 1)'(MIN_FREE);

    // Circular byte store; the output register holds one more byte, and both count toward level.
    logic [7:0]       mem [DEPTH];

    logic [ASIZE-1:0] wr_ptr_q, wr_ptr_d;
    logic [ASIZE-1:0] rd_ptr_q, rd_ptr_d;
    logic [ASIZE:0]   level_q, level_d;
    logic             out_valid_q, out_valid_d;
    logic [7:0]       out_data_q, out_data_d;
    logic             overflow_q, overflow_d;

    logic             deliver;
    logic             full;
    logic             store;
    logic             drop;
    logic [ASIZE:0]   mem_cnt;
    logic             mem_empty;
    logic             load;
    logic             bypass;
    logic             mem_wr;

    // Handshake decode: a full buffer still accepts a byte when one leaves on the same edge.
    always_comb begin
        deliver   = out_valid_q & out_ready;
        full      = (level_q == FULL_LEVEL);
        store     = in_valid & ~clear & (~full | deliver);
        drop      = in_valid & ~clear & full & ~deliver;
        mem_cnt   = level_q - {{ASIZE{1'b0}}, out_valid_q};
        mem_empty = (mem_cnt == '0);
        load      = ~out_valid_q | deliver;
        // With nothing queued in memory, an incoming byte goes straight to the output register.
        bypass    = load & mem_empty & store;
        mem_wr    = store & ~bypass;
    end

    // Next-state for pointers, level, sticky overflow and the output register.
    always_comb begin
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        level_d     = level_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        overflow_d  = overflow_q;
        if (clear) begin
            wr_ptr_d    = '0;
            rd_ptr_d    = '0;
            level_d     = '0;
            out_valid_d = 1'b0;
            overflow_d  = 1'b0;
        end else begin
            level_d    = level_q + {{ASIZE{1'b0}}, store} - {{ASIZE{1'b0}}, deliver};
            overflow_d = overflow_q | drop;
            if (mem_wr) begin
                wr_ptr_d = wr_ptr_q + ASIZE'(1);
            end
            if (load) begin
                if (!mem_empty) begin
                    out_data_d  = mem[rd_ptr_q];
                    rd_ptr_d    = rd_ptr_q + ASIZE'(1);
                    out_valid_d = 1'b1;
                end else if (bypass) begin
                    out_data_d  = in_data;
                    out_valid_d = 1'b1;
                end else begin
                    out_valid_d = 1'b0;
                end
            end
        end
    end

    // Byte memory write port; contents need no reset.
    always_ff @(posedge clk) begin
        if (mem_wr) begin
            mem[wr_ptr_q] <= in_data;
        end
    end

    // State registers with asynchronous reset so an unplug empties the buffer at once.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            level_q     <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= 8'h00;
            overflow_q  <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            level_q     <= level_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            overflow_q  <= overflow_d;
        end
    end

    // Space-based ready derived from registered level only.
    always_comb begin
        in_ready = ((FULL_LEVEL - level_q) >= MIN_FREE_L);
    end

    assign out_data  = out_data_q;
    assign out_valid = out_valid_q;
    assign level     = level_q;
    assign overflow  = overflow_q;

endmodule
